imem_fetch_arbiter: RTL

//  Shares the single synchronous-read instruction memory between two read requesters:

---
 rtl/imem_fetch_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// imem_fetch_arbiter
//
// Shares one synchronous-read instruction memory between two read requesters:
//   port 0 : CPU instruction fetch
//   port 1 : debug / loader readback
//
// Only one access is in flight at a time. The FSM walks IDLE -> ISSUE -> RESP.
// A legal request drives the registered word address to the memory in ISSUE.
// The memory returns the word one clock later, and that word is presented in
// RESP. An illegal request skips the memory entirely. It goes straight to RESP
// with rsp_err set and zero data.
//
// Optional feature macro:
//   IMEM_ARB_RR_EN  defined   -> round-robin arbitration. A 1-bit last-grant
//                                pointer is kept for this.
//                   undefined -> fixed priority, with port 0 first.
//
// Ports:
//   clock, resetn          rising-edge clock, asynchronous active-low reset
//   req0_valid/ready/addr  port 0 request channel (byte address)
//   req1_valid/ready/addr  port 1 request channel (byte address)
//   rsp0_valid, rsp1_valid response valid for the granted port
//   rsp_ready              the addressed port accepts its response
//   rsp_data               response word, shared by both ports (0 on error)
//   rsp_err                misaligned or out-of-range request
//   mem_addr               registered word address to the memory
//   mem_rdata              memory read data, valid one cycle after sampling
// ---------------------------------------------------------------------------
module imem_fetch_arbiter #(
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 131072,
  localparam int MEM_AW = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The limit is computed in 64 bits, so DEPTH*4 cannot wrap for any
  // ADDR_W up to 64.
  localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic              port_q;     // granted port of the access in flight
  logic              grant1;     // arbitration result: 1 selects port 1
  logic              idle;
  logic              handshake;
  logic [ADDR_W-1:0] sel_addr;
  logic              legal;

`ifdef IMEM_ARB_RR_EN
  logic              last_grant; // port granted at the most recent handshake
`endif

  assign idle = (state == IDLE);

  // Arbitration
  always_comb begin
    grant1 = 1'b0;
`ifdef IMEM_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      grant1 = ~last_grant;
    end else begin
      grant1 = req1_valid;
    end
`else
    grant1 = req1_valid && !req0_valid;
`endif
  end

  // Ready is gated by resetn, so no grant is visible while reset is held.
  assign req0_ready = resetn && idle && req0_valid && !grant1;
  assign req1_ready = resetn && idle && req1_valid &&  grant1;
  assign handshake  = req0_ready || req1_ready;

  assign sel_addr = grant1 ? req1_addr : req0_addr;
  assign legal    = (sel_addr[1:0] == 2'b00) && (64'(sel_addr) < BYTE_LIMIT);

  // mem_addr stays unchanged through RESP, so the memory keeps returning
  // the same word while the response is held.
  assign rsp_data = ((rsp0_valid || rsp1_valid) && !rsp_err) ? mem_rdata
                                                             : '0;

  // FSM; the response valid/err outputs come from registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      port_q     <= 1'b0;
      mem_addr   <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            port_q <= grant1;
            if (legal) begin
              mem_addr <= sel_addr[MEM_AW+1:2];
              state    <= ISSUE;
            end else begin
              // Error path: the memory address is left untouched.
              rsp_err    <= 1'b1;
              rsp0_valid <= ~grant1;
              rsp1_valid <=  grant1;
              state      <= RESP;
            end
          end
        end
        ISSUE: begin
          rsp_err    <= 1'b0;
          rsp0_valid <= ~port_q;
          rsp1_valid <=  port_q;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp_err    <= 1'b0;
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Last-grant pointer, updated on every request handshake
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 1'b0;
    end else if (handshake) begin
      last_grant <= grant1;
    end
  end
`endif

endmodule
